axis_fifo: RTL and testbench

AXIS_FIFO -- requirements
Module: axis_fifo

---
 rtl/axis_fifo.sv | 147 ++++++++++++++
 tb/tb_axis_fifo.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo.sv
// axis_fifo: AXI-Stream first-word fall-through FIFO; each entry holds tdata plus tlast.
// Define AXIS_FIFO_PACKET_MODE_EN to hold m_axis_tvalid until a complete packet (or a full FIFO) is stored.
module axis_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic                    almost_full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = DATA_WIDTH + 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [EW-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          af_q, af_d;
  logic          s_rdy_q, s_rdy_d;
  logic          m_vld_q, m_vld_d;
  logic          wr_en;
  logic          rd_en;

  assign wr_en = s_axis_tvalid && s_rdy_q;
  assign rd_en = m_vld_q && m_axis_tready;

  // Pointer, occupancy and status-flag next state; flags come from the next count so they register in step.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    empty_d = (count_d == CNT_ZERO);
    full_d  = (count_d == DEPTH_C);
    af_d    = (count_d >= AF_C);
    s_rdy_d = !full_d;
  end

`ifdef AXIS_FIFO_PACKET_MODE_EN
  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;

  // Count of complete packets currently held.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    case ({wr_en && s_axis_tlast, rd_en && m_axis_tlast})
      2'b10:   pkt_cnt_d = pkt_cnt_q + CNT_ONE;
      2'b01:   pkt_cnt_d = pkt_cnt_q - CNT_ONE;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  // Packet counter register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      pkt_cnt_q <= CNT_ZERO;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  // A full FIFO releases data even without a tlast so oversized packets cannot deadlock.
  always_comb begin
    m_vld_d = !empty_d && ((pkt_cnt_d != CNT_ZERO) || full_d);
  end
`else
  // Any stored beat is presentable.
  always_comb begin
    m_vld_d = !empty_d;
  end
`endif

  // Control and status registers; ready stays low while in reset and rises on the first edge after.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= CNT_ZERO;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      s_rdy_q  <= 1'b0;
      m_vld_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      af_q     <= af_d;
      s_rdy_q  <= s_rdy_d;
      m_vld_q  <= m_vld_d;
    end
  end

  // Beat storage; contents are not cleared by reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {s_axis_tlast, s_axis_tdata};
    end
  end

  assign {m_axis_tlast, m_axis_tdata} = mem_q[rd_ptr_q];
  assign s_axis_tready = s_rdy_q;
  assign m_axis_tvalid = m_vld_q;
  assign count_o       = count_q;
  assign empty_o       = empty_q;
  assign full_o        = full_q;
  assign almost_full_o = af_q;

endmodule

// File: tb/tb_axis_fifo.sv
// tb_axis_fifo: directed vector table plus hand-written sequences for fill, streaming, backpressure and reset.
module tb_axis_fifo;

  logic       clk_i = 1'b0;
  logic       rstn_i = 1'b0;
  logic [7:0] s_axis_tdata = 8'h00;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tlast = 1'b0;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tlast;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b0;
  logic [4:0] count_o;
  logic       full_o, empty_o, almost_full_o;

`ifdef AXIS_FIFO_PACKET_MODE_EN
  localparam bit PKT = 1'b1;
`else
  localparam bit PKT = 1'b0;
`endif

  axis_fifo dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o),
    .almost_full_o(almost_full_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       rstn;
    logic       sv;
    logic [7:0] sd;
    logic       mr;
    logic [4:0] cnt;
    logic       emp;
    logic       ful;
    logic       af;
    logic       srdy;
    logic       mvld;
    logic [7:0] md;
  } vec_t;

  vec_t tbl[15];
  int   n_pass = 0;
  int   n_chk  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic rst, input logic sv, input logic [7:0] sd,
                       input logic sl, input logic mr);
    rstn_i        = rst;
    s_axis_tvalid = sv;
    s_axis_tdata  = sd;
    s_axis_tlast  = sl;
    m_axis_tready = mr;
  endtask

  logic [8:0] sbq[$];
  logic [8:0] exp_beat;
  logic [7:0] exp_seq[17];
  logic [7:0] held;
  bit         wr, rd, stall;
  int         sent, got, cyc;

  initial begin
    // rstn sv data mr | cnt emp ful af srdy mvld md
    tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 8'h99, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 1'b1, 8'h11, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11};
    tbl[4]  = '{1'b1, 1'b1, 8'h22, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11};
    tbl[5]  = '{1'b1, 1'b1, 8'h33, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11};
    tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22};
    tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33};
    tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[10] = '{1'b1, 1'b1, 8'h44, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h44};
    tbl[11] = '{1'b1, 1'b1, 8'h55, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55};
    tbl[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55};
    tbl[13] = '{1'b0, 1'b1, 8'h66, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[14] = '{1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].rstn, tbl[i].sv, tbl[i].sd, 1'b1, tbl[i].mr);
      step();
      chk($sformatf("v%0d count", i), 32'(count_o), 32'(tbl[i].cnt));
      chk($sformatf("v%0d empty", i), 32'(empty_o), 32'(tbl[i].emp));
      chk($sformatf("v%0d full", i), 32'(full_o), 32'(tbl[i].ful));
      chk($sformatf("v%0d afull", i), 32'(almost_full_o), 32'(tbl[i].af));
      chk($sformatf("v%0d s_ready", i), 32'(s_axis_tready), 32'(tbl[i].srdy));
      chk($sformatf("v%0d m_valid", i), 32'(m_axis_tvalid), 32'(tbl[i].mvld));
      if (tbl[i].mvld) begin
        chk($sformatf("v%0d m_data", i), 32'(m_axis_tdata), 32'(tbl[i].md));
        chk($sformatf("v%0d m_last", i), 32'(m_axis_tlast), 32'd1);
      end
    end

    // Fill to full, hold a 17th beat until a read frees a slot, then drain in order.
    for (int k = 1; k <= 16; k++) begin
      exp_seq[k-1] = 8'hA0 + 8'(k - 1);
      drive(1'b1, 1'b1, exp_seq[k-1], 1'b1, 1'b0);
      step();
      chk($sformatf("fill%0d count", k), 32'(count_o), 32'(k));
      chk($sformatf("fill%0d afull", k), 32'(almost_full_o), 32'(k >= 14));
      chk($sformatf("fill%0d full", k), 32'(full_o), 32'(k == 16));
      chk($sformatf("fill%0d s_ready", k), 32'(s_axis_tready), 32'(k != 16));
    end
    exp_seq[16] = 8'hEE;
    drive(1'b1, 1'b1, 8'hEE, 1'b1, 1'b0);
    step();
    step();
    chk("held17 count", 32'(count_o), 32'd16);
    drive(1'b1, 1'b1, 8'hEE, 1'b1, 1'b1);
    step();
    chk("full rd+wr count", 32'(count_o), 32'd15);
    chk("full rd+wr m_data", 32'(m_axis_tdata), 32'hA1);
    chk("full rd+wr s_ready", 32'(s_axis_tready), 32'd1);
    drive(1'b1, 1'b1, 8'hEE, 1'b1, 1'b0);
    step();
    chk("beat17 count", 32'(count_o), 32'd16);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int j = 1; j <= 16; j++) begin
      chk($sformatf("drain%0d m_data", j), 32'(m_axis_tdata), 32'(exp_seq[j]));
      step();
    end
    chk("drained empty", 32'(empty_o), 32'd1);

    // Streaming with both sides always ready; pointers wrap twice.
    drive(1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
    step();
    for (int c = 0; c < 40; c++) begin
      drive(1'b1, 1'b1, 8'(c + 1), 1'b1, 1'b1);
      chk($sformatf("stream%0d m_data", c), 32'(m_axis_tdata), 32'(8'(c)));
      step();
      chk($sformatf("stream%0d count", c), 32'(count_o), 32'd1);
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    step();
    chk("stream end empty", 32'(empty_o), 32'd1);

    // Reset with five beats stored.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 8'(k), 1'b1, 1'b0);
      step();
    end
    chk("pre-reset count", 32'(count_o), 32'd5);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    chk("mid-reset count", 32'(count_o), 32'd0);
    chk("mid-reset empty", 32'(empty_o), 32'd1);
    chk("mid-reset m_valid", 32'(m_axis_tvalid), 32'd0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    chk("post-reset s_ready", 32'(s_axis_tready), 32'd1);

    // Three-beat packet: valid only after the tlast beat in packet mode.
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 1'b1, 8'(8'h30 + k), k == 3, 1'b0);
      step();
      chk($sformatf("pkt beat%0d m_valid", k), 32'(m_axis_tvalid), 32'((k == 3) || !PKT));
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step();

    // Oversized packet without tlast: released once full.
    for (int k = 1; k <= 16; k++) begin
      drive(1'b1, 1'b1, 8'(k), 1'b0, 1'b0);
      step();
      chk($sformatf("big%0d m_valid", k), 32'(m_axis_tvalid), 32'((k == 16) || !PKT));
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step();

    // Random valid/ready backpressure against a scoreboard.
    sent = 0;
    got  = 0;
    cyc  = 0;
    while ((got < 1000) && (cyc < 20000)) begin
      drive(1'b1, (sent < 1000) && ($urandom_range(0, 3) != 0), 8'(sent) ^ 8'h5A,
            ((sent % 7) == 6) || (sent == 999), $urandom_range(0, 2) != 0);
      wr    = s_axis_tvalid && s_axis_tready;
      rd    = m_axis_tvalid && m_axis_tready;
      stall = m_axis_tvalid && !m_axis_tready;
      held  = m_axis_tdata;
      if (rd) begin
        if (sbq.size() == 0) begin
          chk("rand underflow", 32'd1, 32'd0);
        end else begin
          exp_beat = sbq.pop_front();
          chk("rand beat", 32'({m_axis_tlast, m_axis_tdata}), 32'(exp_beat));
        end
        got++;
      end
      if (wr) begin
        sbq.push_back({s_axis_tlast, s_axis_tdata});
        sent++;
      end
      step();
      if (stall) begin
        chk("stall m_valid", 32'(m_axis_tvalid), 32'd1);
        chk("stall m_data", 32'(m_axis_tdata), 32'(held));
      end
      cyc++;
    end
    chk("rand beats received", 32'(got), 32'd1000);
    chk("rand end count", 32'(count_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
